// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM states, default width,
// and the bit-counter sizing rule.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // A 1-bit datapath still needs a 1-bit counter, so clamp at one.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell consumes one operand bit per
// clock, LSB first, and the result is published on the edge entering DONE.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int            CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  adder_state_t     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carryOut;
  logic             r_overflow;

  logic             w_bitSum;
  logic             w_bitCout;
  logic [WIDTH-1:0] w_nextAcc;

  full_adder u_cell (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .o_sum (w_bitSum),
    .o_cout(w_bitCout)
  );

  // Result bits enter at the MSB so the LSB-first stream lands in place.
  always_comb begin
    w_nextAcc            = r_acc >> 1;
    w_nextAcc[WIDTH-1]   = w_bitSum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_sum      <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so invert B and seed the carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : carry_in;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_bitCout;
          r_acc   <= w_nextAcc;
          if (r_cnt == LAST) begin
            // On the MSB step r_carry is the carry into the MSB.
            r_sum      <= w_nextAcc;
            r_carryOut <= w_bitCout;
            r_overflow <= r_carry ^ w_bitCout;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  mode: 0 = a+b+carry_in, 1 = a-b (carry_in ignored); captured with start.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement; captured with start.
REQ-007 b  input  WIDTH  operand B; captured with start.
REQ-008 carry_in  input  1  carry into bit 0 in add mode; captured with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when a result is loaded.
REQ-011 sum  output  WIDTH  registered result, held until next completion.
REQ-012 carry_out  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-013 overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Function
REQ-014 SHALL be a bit-serial adder: one full-adder cell processes one bit per clock, LSB first.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH RUN edges; DONE->IDLE unconditionally after one cycle.
REQ-016 On the edge start is sampled high in IDLE (edge k), a, b (inverted if sub=1), and initial carry (carry_in if sub=0, 1 if sub=1) SHALL be loaded into internal registers, bit counter cleared.
REQ-017 Edges k+1..k+WIDTH SHALL each process one bit, shifting operands right and updating the carry register; edge k+WIDTH also enters DONE.
REQ-018 sum, carry_out, overflow SHALL update only on the edge entering DONE (edge k+WIDTH); done SHALL be high exactly for the following cycle.
REQ-019 busy SHALL be high in RUN only; low in IDLE and DONE.
REQ-020 start while busy or in DONE SHALL be ignored; a, b, sub, carry_in changes during RUN SHALL not affect the result.
REQ-021 Back-to-back: start held high continuously SHALL yield one operation every WIDTH+2 cycles (IDLE, WIDTH x RUN, DONE).
REQ-022 Result SHALL equal (a + b + carry_in) mod 2^WIDTH in add mode and (a - b) mod 2^WIDTH in sub mode.
REQ-023 WIDTH=1 SHALL work: single RUN cycle, overflow = carry into bit 0 XOR carry out.
REQ-024 Bit counter width SHALL be max(1, clog2(WIDTH)); terminal count WIDTH-1, no wrap beyond.

Reset
REQ-025 reset SHALL force IDLE and clear busy, done, sum, carry_out, overflow, counter, operand and carry registers to 0.
REQ-026 reset asserted mid-RUN SHALL abort the operation; no done pulse, previous result lost (outputs 0).
REQ-027 reset and start high on the same edge: reset wins; start SHALL be ignored.

Structure
REQ-028 Shared package adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default WIDTH constant.
REQ-029 The per-bit cell SHALL be the existing full_adder module instantiated once; no other sub-module.

Verification (WIDTH=8)
REQ-030 a=0xFF, b=0x01, cin=0, sub=0 -> done 8 edges after start edge; sum=0x00, carry_out=1, overflow=0.
REQ-031 a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, carry_out=0, overflow=1.
REQ-032 a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0, overflow=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
REQ-033 start pulsed again 3 cycles into RUN with different operands -> ignored; single done, result of first operands.
REQ-034 reset asserted 4 cycles into RUN -> busy low next cycle, no done, all outputs 0; new start afterwards completes normally.
REQ-035 start held high 3 operations -> done pulses spaced exactly 10 cycles apart, busy low one cycle in DONE and IDLE between runs.
